// File: rtl/shot_aim_controller.sv
// Shot aiming front end: turns key levels into clamped charge pulses and a
// release pulse, gated by a ball-stopped detector that watches the mover position.
module shot_aim_controller #(
  parameter int MAX_STEPS       = 5,
  parameter int REPEAT_FRAMES   = 8,
  parameter int STILL_FRAMES    = 4,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyUp,
  input  logic               keyDown,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               keyShoot,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               chargeUp,
  output logic               chargeDown,
  output logic               chargeLeft,
  output logic               chargeRight,
  output logic               releaseBall,
  output logic signed [3:0]  shotStepX,
  output logic signed [3:0]  shotStepY,
  output logic               readyToShoot
);

  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam int SW = $clog2(STILL_FRAMES + 1);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic signed [4:0] MAX_S = 5'(MAX_STEPS);

  typedef enum logic [1:0] {WAIT_STILL, AIM, COOLDOWN} state_t;

  state_t                state_q;
  logic [SW-1:0]         still_cnt_q;
  logic [CW-1:0]         cool_cnt_q;
  logic signed [10:0]    prev_x_q, prev_y_q;
  logic [3:0]            key_lvl, key_prev_q, rep_hit, req, grant, charge_q;
  logic                  shoot_prev_q, release_q, ready_q, in_aim, fire;
  logic signed [3:0]     step_x_q, step_y_q;
  logic signed [4:0]     sx_w, sy_w, step_x_d, step_y_d;

  // Key index: 0 = up, 1 = down, 2 = left, 3 = right.
  assign key_lvl = {keyRight, keyLeft, keyDown, keyUp};
  // A stillCnt of 0 while in AIM means the ball was knocked; treat as not aiming.
  assign in_aim  = (state_q == AIM) && (still_cnt_q != '0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_repeat
    logic [RW-1:0] rep_q;

    assign rep_hit[gi] = in_aim && key_lvl[gi] && startOfFrame &&
                         (rep_q == RW'(REPEAT_FRAMES - 1));
    assign req[gi]     = in_aim && ((key_lvl[gi] && !key_prev_q[gi]) || rep_hit[gi]);

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                       rep_q <= '0;
      else if (!in_aim || !key_lvl[gi])  rep_q <= '0;
      else if (startOfFrame)             rep_q <= rep_hit[gi] ? '0 : rep_q + 1'b1;
    end
  end

  assign sx_w = {step_x_q[3], step_x_q};
  assign sy_w = {step_y_q[3], step_y_q};

  always_comb begin
    grant = req;
    if (req[0] && req[1]) grant[1:0] = 2'b00;
    if (req[2] && req[3]) grant[3:2] = 2'b00;
    if (sy_w + 5'sd1 >  MAX_S) grant[0] = 1'b0;
    if (sy_w - 5'sd1 < -MAX_S) grant[1] = 1'b0;
    if (sx_w + 5'sd1 >  MAX_S) grant[2] = 1'b0;
    if (sx_w - 5'sd1 < -MAX_S) grant[3] = 1'b0;
    fire     = in_aim && keyShoot && !shoot_prev_q &&
               ((step_x_q != '0) || (step_y_q != '0));
    step_y_d = sy_w + $signed({4'b0, grant[0]}) - $signed({4'b0, grant[1]});
    step_x_d = sx_w + $signed({4'b0, grant[2]}) - $signed({4'b0, grant[3]});
  end

  // Still detector; held at zero through cooldown so a stale position cannot count.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      still_cnt_q <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
    end else begin
      if (startOfFrame) begin
        prev_x_q <= topLeftX;
        prev_y_q <= topLeftY;
      end
      if (state_q == COOLDOWN || fire)
        still_cnt_q <= '0;
      else if (startOfFrame) begin
        if (topLeftX == prev_x_q && topLeftY == prev_y_q) begin
          if (still_cnt_q != SW'(STILL_FRAMES)) still_cnt_q <= still_cnt_q + 1'b1;
        end else
          still_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= WAIT_STILL;
      cool_cnt_q   <= '0;
      key_prev_q   <= '0;
      shoot_prev_q <= 1'b0;
      charge_q     <= '0;
      release_q    <= 1'b0;
      ready_q      <= 1'b0;
      step_x_q     <= '0;
      step_y_q     <= '0;
    end else begin
      key_prev_q   <= key_lvl;
      shoot_prev_q <= keyShoot;
      charge_q     <= fire ? 4'b0000 : grant;
      release_q    <= fire;
      if (fire) begin
        step_x_q <= '0;
        step_y_q <= '0;
      end else begin
        step_x_q <= step_x_d[3:0];
        step_y_q <= step_y_d[3:0];
      end
      case (state_q)
        WAIT_STILL: begin
          if (still_cnt_q == SW'(STILL_FRAMES)) begin
            state_q <= AIM;
            ready_q <= 1'b1;
          end
        end
        AIM: begin
          if (still_cnt_q == '0) begin
            state_q <= WAIT_STILL;
            ready_q <= 1'b0;
          end else if (fire) begin
            state_q    <= COOLDOWN;
            ready_q    <= 1'b0;
            cool_cnt_q <= '0;
          end
        end
        COOLDOWN: begin
          if (startOfFrame) begin
            if (cool_cnt_q == CW'(COOLDOWN_FRAMES - 1)) begin
              cool_cnt_q <= '0;
              state_q    <= WAIT_STILL;
            end else
              cool_cnt_q <= cool_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_STILL;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign chargeUp     = charge_q[0];
  assign chargeDown   = charge_q[1];
  assign chargeLeft   = charge_q[2];
  assign chargeRight  = charge_q[3];
  assign releaseBall  = release_q;
  assign shotStepX    = step_x_q;
  assign shotStepY    = step_y_q;
  assign readyToShoot = ready_q;

endmodule

// File: tb/tb_shot_aim_controller.sv
// Bench for shot_aim_controller: directed scenarios then random key/position
// traffic, every cycle compared against a frame-level behavioural model.
module tb_shot_aim_controller;

  localparam int MAXS  = 5;
  localparam int REP   = 8;
  localparam int STILL = 4;
  localparam int COOL  = 2;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic startOfFrame = 1'b0;
  logic keyUp = 1'b0, keyDown = 1'b0, keyLeft = 1'b0, keyRight = 1'b0, keyShoot = 1'b0;
  logic signed [10:0] topLeftX = '0, topLeftY = '0;
  logic chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, readyToShoot;
  logic signed [3:0] shotStepX, shotStepY;

  shot_aim_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .keyUp(keyUp), .keyDown(keyDown), .keyLeft(keyLeft), .keyRight(keyRight),
    .keyShoot(keyShoot), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .chargeUp(chargeUp), .chargeDown(chargeDown), .chargeLeft(chargeLeft),
    .chargeRight(chargeRight), .releaseBall(releaseBall),
    .shotStepX(shotStepX), .shotStepY(shotStepY), .readyToShoot(readyToShoot)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_left = 0;

  // Reference model: aiming flag, frames of cooldown left, frames seen still.
  bit       m_aiming;
  int       m_cool_left, m_still, m_px, m_py, m_sx, m_sy;
  int       m_held [4];
  bit [3:0] m_prevk;
  bit       m_prevsh;
  bit [3:0] e_pulse;
  bit       e_rel;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("pulses", {chargeRight, chargeLeft, chargeDown, chargeUp}, e_pulse);
    check("release", releaseBall, e_rel);
    check("stepX", shotStepX, m_sx);
    check("stepY", shotStepY, m_sy);
    check("ready", readyToShoot, m_aiming);
  endtask

  task automatic model_reset();
    m_aiming = 0; m_cool_left = 0; m_still = 0; m_px = 0; m_py = 0;
    m_sx = 0; m_sy = 0; m_prevk = '0; m_prevsh = 0; e_pulse = '0; e_rel = 0;
    for (int i = 0; i < 4; i++) m_held[i] = 0;
  endtask

  task automatic model_step(input bit sof, input bit [3:0] k, input bit sh, input int x, input int y);
    bit live, fire;
    bit [3:0] rq, ok;
    int old_still, old_cool;
    live = m_aiming && (m_still != 0);
    for (int i = 0; i < 4; i++) begin
      bit hit;
      hit = 0;
      if (live && k[i]) begin
        if (sof) begin
          m_held[i]++;
          hit = (m_held[i] % REP) == 0;
        end
      end else
        m_held[i] = 0;
      rq[i] = live && ((k[i] && !m_prevk[i]) || hit);
    end
    if (rq[0] && rq[1]) rq[1:0] = 2'b00;
    if (rq[2] && rq[3]) rq[3:2] = 2'b00;
    ok[0] = rq[0] && (m_sy + 1 <=  MAXS);
    ok[1] = rq[1] && (m_sy - 1 >= -MAXS);
    ok[2] = rq[2] && (m_sx + 1 <=  MAXS);
    ok[3] = rq[3] && (m_sx - 1 >= -MAXS);
    fire = live && sh && !m_prevsh && (m_sx != 0 || m_sy != 0);
    if (fire) begin
      e_pulse = '0; e_rel = 1; m_sx = 0; m_sy = 0;
    end else begin
      e_pulse = ok; e_rel = 0;
      m_sy = m_sy + int'(ok[0]) - int'(ok[1]);
      m_sx = m_sx + int'(ok[2]) - int'(ok[3]);
    end
    old_still = m_still;
    old_cool  = m_cool_left;
    if (old_cool > 0) begin
      if (sof) m_cool_left--;
    end else if (m_aiming) begin
      if (old_still == 0) m_aiming = 0;
      else if (fire) begin m_aiming = 0; m_cool_left = COOL; end
    end else if (old_still == STILL)
      m_aiming = 1;
    if (old_cool > 0 || fire) m_still = 0;
    else if (sof) m_still = (x == m_px && y == m_py) ? ((m_still < STILL) ? m_still + 1 : STILL) : 0;
    if (sof) begin m_px = x; m_py = y; end
    m_prevk  = k;
    m_prevsh = sh;
  endtask

  task automatic cyc(input bit sof, input bit [3:0] k, input bit sh, input int x, input int y);
    @(negedge clk);
    startOfFrame = sof;
    {keyRight, keyLeft, keyDown, keyUp} = k;
    keyShoot = sh;
    topLeftX = 11'(x);
    topLeftY = 11'(y);
    model_step(sof, k, sh, x, y);
    @(posedge clk);
    #1;
    if (chargeLeft) cnt_left++;
    check_all();
  endtask

  task automatic frames(input int n, input bit [3:0] k, input bit sh, input int x, input int y);
    for (int f = 0; f < n; f++)
      for (int j = 0; j < 4; j++) cyc(j == 0, k, sh, x, y);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    startOfFrame = 0; {keyRight, keyLeft, keyDown, keyUp} = '0; keyShoot = 0;
    resetN = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    resetN = 1;
  endtask

  initial begin
    bit [3:0] rk;
    bit rsh, rsof;
    int rx, ry;

    #2;
    do_reset();
    frames(5, 4'b0000, 0, 100, 50);
    check("ready_after_still", readyToShoot, 1);

    cyc(0, 4'b0001, 0, 100, 50);
    check("up_pulse", chargeUp, 1);
    cyc(0, 4'b0000, 0, 100, 50);
    check("up_stepY", shotStepY, 1);

    cnt_left = 0;
    frames(60, 4'b0100, 0, 100, 50);
    check("left_pulse_count", cnt_left, 5);
    check("left_clamp", shotStepX, 5);
    frames(1, 4'b0000, 0, 100, 50);

    cyc(0, 4'b0011, 0, 100, 50);
    check("updown_cancel", {chargeDown, chargeUp}, 0);
    cyc(0, 4'b0000, 0, 100, 50);
    cyc(0, 4'b1001, 0, 100, 50);
    check("up_right_pulse", {chargeRight, chargeUp}, 2'b11);
    cyc(0, 4'b0000, 0, 100, 50);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'b0010, 0, 100, 50);
      cyc(0, 4'b0000, 0, 100, 50);
    end
    check("stepY_neg3", shotStepY, -3);

    cyc(0, 4'b0000, 1, 100, 50);
    check("fire_release", releaseBall, 1);
    check("fire_clearY", shotStepY, 0);
    cyc(0, 4'b0000, 0, 100, 50);
    frames(2, 4'b0000, 0, 100, 50);
    for (int f = 0; f < 6; f++) frames(1, 4'b0000, 0, 200 + f, 50);
    check("moving_not_ready", readyToShoot, 0);
    frames(5, 4'b0000, 0, 205, 50);
    check("frozen_ready", readyToShoot, 1);

    cyc(0, 4'b0000, 1, 205, 50);
    check("zero_shot_ignored", releaseBall, 0);
    cyc(0, 4'b0000, 0, 205, 50);
    cyc(0, 4'b0001, 0, 205, 50);
    cyc(0, 4'b0000, 0, 205, 50);
    cyc(0, 4'b0000, 1, 205, 50);
    check("second_fire", releaseBall, 1);
    cyc(0, 4'b0000, 0, 205, 50);
    do_reset();
    check("reset_ready", readyToShoot, 0);

    rk = '0; rsh = 0; rx = 100; ry = 50;
    for (int c = 0; c < 4000; c++) begin
      rsof = ($urandom_range(3) == 0);
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) rk[i] = ~rk[i];
      if ($urandom_range(11) == 0) rsh = ~rsh;
      if (rsof && $urandom_range(9) == 0) rx = 100 + ((rx + 1 + int'($urandom_range(2))) % 500);
      if (rsof && $urandom_range(19) == 0) ry = 50 + ((ry + 3) % 300);
      if (c == 2000) begin
        do_reset();
        rk = '0; rsh = 0;
      end
      cyc(rsof, rk, rsh, rx, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
